fila_param: RTL
===============

// Module: fila_param
// PURPOSE
// - Parametrised FIFO queue; successor to the fixed 8x8 queue.
// - Generic width/depth; edge-triggered enqueue/dequeue (one op per request press).
// - Adds full/empty flags, sticky overflow/underflow errors, optional head-peek output mode.
// - Sits between the user-input/debounce logic and the display/consumer logic in the 10 kHz domain.
// PARAMETERS
// - DATA_W  8  width of each stored element
// - DEPTH   8  number of entries; power of two >= 2
// - LEN_W   8  width of len_out; must satisfy 2**LEN_W > DEPTH
// - PEEK    0  0: data_out = last dequeued element, held; 1: data_out = current head element (0 when empty)
// PORTS
// - clk_10KHz   in   1       single clock, all state on rising edge
// - reset       in   1       asynchronous, active-high reset
// - data_in     in   DATA_W  element to enqueue
// - enqueue_in  in   1       enqueue request (level; acted on at rising edge only)
// - dequeue_in  in   1       dequeue request (level; acted on at rising edge only)
// - data_out    out  DATA_W  output element (see PEEK)
// - len_out     out  LEN_W   current occupancy, 0..DEPTH
// - full_out    out  1       len_out == DEPTH
// - empty_out   out  1       len_out == 0
// - ovf_out     out  1       sticky: enqueue attempted while full
// - udf_out     out  1       sticky: dequeue attempted while empty
// BEHAVIOUR
// Reset (asynchronous, any time, including mid-operation):
// - wr_ptr = rd_ptr = 0; len_out = 0; data_out = 0; ovf_out = udf_out = 0.
// - Both edge-detector history bits cleared to 0.
// - Storage contents are don't-care and not observable.
// - empty_out = 1, full_out = 0.
// Request detection:
// - enq_ev = enqueue_in & ~enq_prev; deq_ev likewise; history bits registered every cycle.
// - A request held N cycles yields exactly one event.
// - A request high at the first edge after reset release counts as an event.
// Timing: event sampled at edge k -> storage, pointers, len_out, flags and data_out updated at edge k.
// - No extra latency.
// - full_out and empty_out decode combinationally from the registered count.
// Enqueue only:
// - Not full: mem[wr_ptr] <= data_in; wr_ptr+1 (mod DEPTH); len+1.
// - Full: data dropped, no state change except ovf_out <= 1.
// Dequeue only:
// - Not empty: rd_ptr+1 (mod DEPTH); len-1.
// - PEEK=0: data_out <= mem[rd_ptr].
// - Empty: udf_out <= 1; data_out held.
// Both events in the same cycle:
// - Not empty and not full: write and read both performed; len unchanged.
// - Full: read performed, then write into the freed slot; len stays DEPTH; no overflow.
// - Empty: enqueue performed, dequeue rejected; udf_out <= 1; len = 1.
// - No fall-through: the new element is not returned in the same cycle.
// Pointers: LOG2(DEPTH) bits; wrap naturally. Occupancy is tracked by the counter, not by pointer compare.
// PEEK=1: data_out = registered mem[rd_ptr] after each update; 0 when empty.
// Sticky flags: ovf_out and udf_out are cleared only by reset.
// STRUCTURE
// - Package fila_pkg:
//   - default DATA_W/DEPTH constants
//   - function clog2_safe
//   - typedef enum {OP_NONE, OP_ENQ, OP_DEQ, OP_BOTH} fila_op_t (decoded event per cycle)
// - Sub-module detector_borda: one-bit rising-edge detector (clk, reset, level_in, pulse_out); two instances.
// - Top: op decode, pointer/count registers, memory array, output regs.
// TESTING (DATA_W=8, DEPTH=8, 10 kHz clock, enqueue pulses 1/2 cycle, dequeue held 5 cycles)
// 1. Fill/overflow:
//    - Stimulus: reset, then enqueue 0x11,0x22,...,0x99.
//    - Required: len_out 1..8, full_out=1 after the 8th; 0x99 dropped; ovf_out=1; len_out stays 8.
// 2. Drain/underflow:
//    - Stimulus: 9 dequeue presses, each held 5 cycles (PEEK=0).
//    - Required: data_out 0x11..0x88, one pop per press; 9th press sets udf_out=1; data_out holds 0x88; empty_out=1.
// 3. Wrap-around:
//    - Stimulus: enqueue 5, dequeue 5, enqueue 0xA0..0xA7, dequeue 8.
//    - Required: outputs 0xA0..0xA7 in order; len_out returns to 0.
// 4. Simultaneous events:
//    - Full + both: len stays 8; head leaves; new data becomes the tail.
//    - Empty + both: len = 1; udf_out=1; later dequeue returns the enqueued value.
// 5. Reset mid-operation: assert reset asynchronously (between clock edges) with len=4 -> all outputs to reset values immediately.
// 6. PEEK=1, DEPTH=4:
//    - Stimulus: enqueue 0x5A, 0x3C.
//    - Required: data_out=0x5A; after one dequeue data_out=0x3C; after the second, 0.

Source files
------------

// File: rtl/fila_param_pkg.sv
// fila_pkg: shared definitions for the parametrised FIFO queue.
//   FILA_DATA_W / FILA_DEPTH : default element width and queue depth
//   clog2_safe()             : ceil(log2(n)), never less than 1 (pointer width)
//   fila_op_t                : request events decoded in one clock cycle
package fila_pkg;

    localparam int FILA_DATA_W = 8;
    localparam int FILA_DEPTH  = 8;

    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ENQ  = 2'b01,
        OP_DEQ  = 2'b10,
        OP_BOTH = 2'b11
    } fila_op_t;

endpackage

// File: rtl/fila_param_if.sv
// fila_param_if: request/data bundle between the input logic and the queue.
//   data_in, enqueue_in, dequeue_in         : requests into the queue
//   data_out, len_out, full_out, empty_out,
//   ovf_out, udf_out                        : queue state seen by the consumer
// slave  = queue side, master = requester/consumer side.
interface fila_param_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic              enqueue_in;
    logic              dequeue_in;
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  len_out;
    logic              full_out;
    logic              empty_out;
    logic              ovf_out;
    logic              udf_out;

    modport slave (
        input  data_in, enqueue_in, dequeue_in,
        output data_out, len_out, full_out, empty_out, ovf_out, udf_out
    );

    modport master (
        output data_in, enqueue_in, dequeue_in,
        input  data_out, len_out, full_out, empty_out, ovf_out, udf_out
    );
endinterface

// File: rtl/fila_param_detector_borda.sv
// detector_borda: one-bit rising-edge detector.
//   clk       : clock
//   reset     : asynchronous active-high reset, clears the history bit
//   level_in  : request level
//   pulse_out : high for the cycle in which level_in is high and was low
//               at the previous edge (history reset to 0, so a level already
//               high at the first edge after reset counts as an edge)
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= level_in;
    end

    assign pulse_out = level_in & ~prev_q;
endmodule

// File: rtl/fila_param.sv
// fila_param: parametrised FIFO queue with edge-triggered enqueue/dequeue.
//   clk_10KHz : clock, all state updates on the rising edge
//   reset     : asynchronous active-high reset
//   bus       : fila_param_if slave (data_in, enqueue_in, dequeue_in in;
//               data_out, len_out, full_out, empty_out, ovf_out, udf_out out)
// Parameters: DATA_W element width, DEPTH entries (power of two >= 2),
// LEN_W occupancy width (2**LEN_W > DEPTH), PEEK selects data_out mode:
//   0 = last dequeued element, held; 1 = current head (0 when empty).
module fila_param
    import fila_pkg::*;
#(
    parameter int DATA_W = FILA_DATA_W,
    parameter int DEPTH  = FILA_DEPTH,
    parameter int LEN_W  = 8,
    parameter int PEEK   = 0
) (
    input  logic          clk_10KHz,
    input  logic          reset,
    fila_param_if.slave   bus
);
    localparam int PTR_W = clog2_safe(DEPTH);

    logic              enq_ev, deq_ev;
    fila_op_t          op;
    logic              full, empty;
    logic              wr_en, rd_en;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] mem [DEPTH];

    detector_borda u_det_enq (
        .clk(clk_10KHz), .reset(reset), .level_in(bus.enqueue_in), .pulse_out(enq_ev)
    );
    detector_borda u_det_deq (
        .clk(clk_10KHz), .reset(reset), .level_in(bus.dequeue_in), .pulse_out(deq_ev)
    );

    assign op    = fila_op_t'({deq_ev, enq_ev});
    assign full  = (len_q == LEN_W'(DEPTH));
    assign empty = (len_q == '0);

    always_comb begin
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        unique case (op)
            OP_ENQ: begin
                if (!full) wr_en = 1'b1;
                else       ovf_d = 1'b1;
            end
            OP_DEQ: begin
                if (!empty) rd_en = 1'b1;
                else        udf_d = 1'b1;
            end
            OP_BOTH: begin
                // A full queue frees its head in the same edge, so the write
                // always has room; an empty queue can only take the write.
                wr_en = 1'b1;
                if (!empty) rd_en = 1'b1;
                else        udf_d = 1'b1;
            end
            default: ;
        endcase
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        len_d    = len_q + LEN_W'(wr_en) - LEN_W'(rd_en);
        // Reads old contents: no fall-through even when wr_ptr == rd_ptr.
        last_d   = rd_en ? mem[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage needs no reset: it is never observable while empty.
    always_ff @(posedge clk_10KHz) begin
        if (wr_en) mem[wr_ptr_q] <= bus.data_in;
    end

    assign bus.data_out  = (PEEK != 0) ? (empty ? '0 : mem[rd_ptr_q]) : last_q;
    assign bus.len_out   = len_q;
    assign bus.full_out  = full;
    assign bus.empty_out = empty;
    assign bus.ovf_out   = ovf_q;
    assign bus.udf_out   = udf_q;
endmodule
